// File: rtl/isqrt_sequencer.sv
// Restoring integer square-root sequencer: one root bit per clock, with the
// trial subtrahend gated to zero whenever the trial subtraction would go negative.
module isqrt_sequencer #(
  parameter int SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE-1:0]     radicand,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [SIZE/2-1:0]   root,
  output logic [SIZE/2:0]     remainder
);

  localparam int R  = SIZE / 2;
  localparam int W  = R + 2;
  localparam int CW = (R > 2) ? $clog2(R) : 1;

  // One-hot encoding so ready/busy/done come straight off state flops.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ITER = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] op_q, op_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [R-1:0]    root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    rem_sh_s;
  logic [W-1:0]    trial_s;
  logic [W-1:0]    sub_s;
  logic            fit_s;

  assign rem_sh_s = {rem_q[W-3:0], op_q[SIZE-1:SIZE-2]};
  assign trial_s  = {root_q, 2'b01};
  assign fit_s    = (rem_sh_s >= trial_s);
  assign sub_s    = fit_s ? trial_s : {W{1'b0}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= {SIZE{1'b0}};
      rem_q   <= {W{1'b0}};
      root_q  <= {R{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = radicand;
          rem_d   = {W{1'b0}};
          root_d  = {R{1'b0}};
          cnt_d   = CW'(R - 1);
          state_d = ITER;
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        // Erased subtrahend keeps rem' unchanged on a failed trial.
        rem_d  = rem_sh_s - sub_s;
        root_d = {root_q[R-2:0], fit_s};
        op_d   = {op_q[SIZE-3:0], 2'b00};
        cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {CW{1'b0}}) begin
          cnt_d   = {CW{1'b0}};
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready     = state_q[0];
  assign busy      = state_q[1];
  assign done      = state_q[2];
  assign root      = root_q;
  assign remainder = rem_q[R:0];

endmodule

// File: tb/tb_isqrt_sequencer.sv
// Directed bench for isqrt_sequencer (SIZE=32): reset, known roots, ignored
// start while busy, mid-run reset, and back-to-back random operations.
module tb_isqrt_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] radicand;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] root;
  logic [16:0] remainder;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  isqrt_sequencer #(.SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .radicand  (radicand),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exactly one status flag high, sampled away from the active edge.
  always @(negedge clk) begin
    check("onehot", {61'd0, ready, busy, done} == 64'd0 ? 64'd0 : 64'($countones({ready, busy, done})), 64'd1);
  end

  task automatic do_op(input string tag, input logic [31:0] r,
                       input logic [15:0] er, input logic [16:0] erem);
    int n;
    bit got;
    @(negedge clk);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    radicand = r;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    radicand = 32'hDEAD_BEEF;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    check({tag, "_lat"}, 64'(n), 64'd16);
    check({tag, "_root"}, 64'(root), 64'(er));
    check({tag, "_rem"}, 64'(remainder), 64'(erem));
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 64'(ready), 64'd1);
    check({tag, "_hold_root"}, 64'(root), 64'(er));
  endtask

  initial begin
    int n;
    int dones;
    bit got;
    int acc_cyc;
    int prev_cyc;
    logic [31:0] rr;
    logic [63:0] sq;

    rst = 1'b1; start = 1'b0; radicand = 32'd0;
    #23;
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 64'(ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_root", 64'(root), 64'd0);
      check("idle_rem", 64'(remainder), 64'd0);
    end

    do_op("r0", 32'd0, 16'd0, 17'd0);
    do_op("r17", 32'd17, 16'd4, 17'd1);
    do_op("r1e6", 32'd1000000, 16'd1000, 17'd0);
    do_op("rmax", 32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    radicand = 32'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    radicand = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; n = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        dones++;
        check("busy_ign_root", 64'(root), 64'd9);
        check("busy_ign_rem", 64'(remainder), 64'd18);
      end
    end
    check("busy_ign_dones", 64'(dones), 64'd1);

    // Reset during ITER cycle 7.
    @(negedge clk);
    radicand = 32'd50000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_root", 64'(root), 64'd0);
    check("rst_rem", 64'(remainder), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("r144", 32'd144, 16'd12, 17'd0);

    // Back-to-back random operations with start held high.
    prev_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
        @(negedge clk);
        n++;
        if (ready) got = 1'b1;
      end
      check("b2b_wait_ready", 64'(got), 64'd1);
      rr = $urandom;
      radicand = rr;
      start = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (i > 0) check("b2b_spacing", 64'(acc_cyc - prev_cyc), 64'd18);
      prev_cyc = acc_cyc;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
        @(posedge clk); #1;
        n++;
        if (done) got = 1'b1;
      end
      check("b2b_lat", 64'(n), 64'd16);
      sq = 64'(root) * 64'(root) + 64'(remainder);
      check("b2b_identity", sq, 64'(rr));
      check("b2b_rem_bound", 64'(remainder <= 17'({1'b0, root} << 1)), 64'd1);
      $display("CSV,%0d,%0d,%0d", rr, root, remainder);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/isqrt_sequencer.md
# isqrt_sequencer

Sequential controller for the integer square-root unit. It accepts an unsigned radicand through a start/ready handshake and runs a restoring digit-by-digit square root, producing one root bit per clock. Each step is a trial subtraction whose subtrahend is erased (gated to zero) when the trial fails. The block sits between the FPU mantissa-sqrt front end and the shared trial-subtract/erase datapath, and owns iteration count, state and result registers.

## Interface
- SIZE, 32, radicand width in bits; must be even and ≥ 4; root width is SIZE/2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- radicand  input  SIZE  unsigned operand; sampled on the accepting edge only
- ready  output  1  high in IDLE; start is accepted on a rising edge where start=1 and ready=1
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; root and remainder are valid from this cycle on
- root  output  SIZE/2  floor(sqrt(radicand))
- remainder  output  SIZE/2+1  radicand − root²

## Operation
- States: IDLE, ITER and DONE. Reset enters IDLE.
- IDLE, with start=1: latch radicand into the operand shift register. Clear the working remainder (SIZE/2+2 bits) and the root. Load the counter with SIZE/2−1. Go to ITER.
- ITER, each cycle:
  - Form rem' = (rem << 2) | top two operand bits.
  - Form trial = (root << 2) | 1, zero-extended to SIZE/2+2 bits.
  - If rem' ≥ trial: rem ← rem' − trial and root ← (root << 1) | 1.
  - Otherwise the subtrahend is erased to 0: rem ← rem' and root ← root << 1.
  - Shift the operand left by 2. Decrement the counter.
  - When the counter is 0 in ITER, go to DONE after this step.
- DONE lasts exactly one cycle, with done=1, then returns to IDLE.
- root and remainder registers hold their values through IDLE until the next accepted start. They are cleared at that accepting edge.
- The remainder output is the low SIZE/2+1 bits of the working remainder. Bit SIZE/2+1 is always 0 at DONE; a nonzero value is a verification error.
- start while busy=1 or done=1: ignored; no queuing. Radicand changes outside the accepting edge have no effect.
- rst asserted at any time, including mid-ITER, aborts the operation immediately, asynchronously:
  - state = IDLE
  - ready=1, busy=0, done=0
  - root=0, remainder=0, counter=0, operand register=0
- All arithmetic is unsigned. Nothing overflows: the working remainder never exceeds 2·root+1 before the shift.

## Timing
- Reset values: ready=1, busy=0, done=0, root=0, remainder=0.
- Accepting edge E0: after E0, ready=0 and busy=1.
- ITER occupies SIZE/2 cycles, covering edges E1..E(SIZE/2). For SIZE=32 that is 16 cycles.
- After edge E(SIZE/2): busy=0, done=1, and outputs are final.
- After edge E(SIZE/2+1): done=0 and ready=1.
- Latency from the accepting edge to done is SIZE/2 cycles.
- Throughput is one operation per SIZE/2+2 cycles. Back-to-back start held high is accepted at E(SIZE/2+2).
- All outputs are registered. There is no combinational path from start or radicand to any output.
- ready, busy and done are mutually exclusive and exactly one is high in every cycle.

## Test plan
All scenarios use SIZE=32.
- Reset then idle, start=0 → ready=1, busy=0, done=0, root=0, remainder=0 held indefinitely.
- radicand=0 → done at 16 cycles after accept; root=0, remainder=0. radicand=17 → root=4, remainder=1.
- radicand=1000000 → root=1000, remainder=0. radicand=0xFFFFFFFF → root=0xFFFF, remainder=0x1FFFE.
- Pulse start with radicand=2 during busy → ignored. The first result (radicand=99 → root=9, remainder=18) is unchanged and there is exactly one done pulse.
- Assert rst at ITER cycle 7, then release and start radicand=144 → immediate outputs all 0 and ready=1; the new run gives root=12, remainder=0 after 16 cycles.
- 100 random radicands, start held high back-to-back → each accept is 18 cycles apart. For each result check root² + remainder = radicand and remainder ≤ 2·root. Log input, root and remainder per operation to CSV.
